nios2_oci_dct_capture: RTL and testbench
========================================

Name: nios2_oci_dct_capture

Overview:
- Parametrised successor to the Nios II OCI test-bench stub.
- Captures data/control-trace (DCT) frames presented by the OCI into a circular buffer and tracks test-end signalling through a small state machine.
- Exposes a valid/ready readout port and status (level, overflow, drop count, done) to the simulation harness or an on-chip debug reader.
- Sits beside the nios2_cpu OCI, same clock domain.

Parameters:
- DCT_W, 30, width of dct_buffer.
- CNT_W, 4, width of dct_count.
- DEPTH, 16, buffer entries; power of two, >= 2.
- WRAP_MODE, 1, 1 = overwrite oldest when full; 0 = drop newest when full.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- dct_buffer  in  DCT_W  trace frame payload.
- dct_count  in  CNT_W  frame entry count; nonzero = frame valid this cycle.
- test_ending  in  1  level; stop capture, begin drain.
- test_has_ended  in  1  level; finalise once buffer is empty.
- rd_ready  in  1  reader accepts rd_data.
- rd_valid  out  1  rd_data holds the oldest entry.
- rd_data  out  CNT_W+DCT_W  {dct_count, dct_buffer} of the oldest entry.
- level  out  clog2(DEPTH)+1  occupied entries.
- overflow  out  1  sticky; an entry was overwritten or dropped.
- drop_count  out  16  saturating count of lost frames.
- capturing  out  1  FSM in CAPTURE.
- done  out  1  FSM in DONE.
- rd_par_err  out  1  see Optional Feature.

Behaviour:
- Reset (async assert, sync deassert by the source): FSM=CAPTURE; pointers=0; level=0; rd_valid=0; rd_data=0; overflow=0; drop_count=0; capturing=1; done=0; rd_par_err=0.
- push = (dct_count != 0) && state==CAPTURE.
- pop = rd_valid && rd_ready.
- Storage: wr_ptr/rd_ptr are clog2(DEPTH) bits and wrap naturally at DEPTH.
- rd_valid = (level != 0).
- rd_data is the registered memory entry at rd_ptr. A push into an empty buffer is visible on rd_valid/rd_data the cycle after the push edge (1-cycle latency).
- Not full: push writes and increments wr_ptr. Pop increments rd_ptr. Simultaneous push+pop leaves level unchanged.
- Full, WRAP_MODE=1, push without pop:
  - write at wr_ptr; advance both pointers; level stays DEPTH.
  - overflow<=1; drop_count+1 (saturates at 0xFFFF).
  - rd_data switches to the next-oldest entry.
- Full, WRAP_MODE=0, push without pop: frame discarded; pointers unchanged; overflow<=1; drop_count+1.
- Full, push+pop (either mode): both accepted; no loss; level stays DEPTH.
- Empty with push+pop: pop is ignored because rd_valid=0; push is accepted.
- FSM states CAPTURE, DRAIN, DONE:
  - CAPTURE -> DRAIN when test_ending=1. A push in that same cycle is still accepted.
  - CAPTURE -> DONE directly when test_has_ended=1 and level==0 after this cycle's push/pop.
  - DRAIN: pushes ignored and not counted as drops; pops continue.
  - DRAIN -> DONE when test_has_ended=1 and level==0 (evaluated after this cycle's pop).
  - DONE: sticky until reset. Pushes are ignored; rd_valid stays 0.
- test_has_ended without test_ending while level != 0: remain in CAPTURE and keep capturing until empty.
- Deasserting test_ending in DRAIN does not return to CAPTURE.
- reset_n low mid-operation: all state clears immediately; buffer contents are not required to clear, but they are unreachable.
- overflow and drop_count clear only on reset.

Optional Feature:
- Macro: NIOS2_OCI_DCT_CAPTURE_PARITY_EN.
- Defined:
  - each entry stores an extra even-parity bit computed over {dct_count, dct_buffer} at write;
  - on each pop the stored bit is rechecked;
  - rd_par_err goes high the cycle after a mismatching pop and is sticky until reset.
- Undefined:
  - no parity storage;
  - rd_par_err is tied 0;
  - port list unchanged.

Test Plan:
- Basic capture and readback:
  - Stimulus: reset, then push 3 frames (dct_count=1,2,3; dct_buffer=0x1, 0x2, 0x3) with rd_ready=0.
  - Required: level=3; rd_data={4'h1, 30'h1}. Then rd_ready=1 for 3 cycles yields the frames in order, and level returns to 0.
- Overwrite when full (WRAP_MODE=1, DEPTH=16):
  - Stimulus: push 18 frames (payloads 0..17), no reads.
  - Required: level=16; overflow=1; drop_count=2; first rd_data payload = 2.
- Drop when full (WRAP_MODE=0):
  - Stimulus: same stimulus as the overwrite case.
  - Required: level=16; drop_count=2; readout payloads 0..15.
  - Then, with the buffer full, push+pop in the same cycle: drop_count stays 2.
- Drain and finish:
  - Stimulus: 5 entries buffered; assert test_ending together with one push; then assert test_has_ended; drain with rd_ready=1.
  - Required: 6 entries read; pushes after that cycle are ignored; done=1 the cycle after the last pop; capturing=0.
- Asynchronous reset mid-operation:
  - Stimulus: level=7, in DRAIN; pulse reset_n low asynchronously between clock edges.
  - Required: level=0, rd_valid=0, overflow=0, capturing=1 immediately, without waiting for a clock edge.
- Parity (macro defined):
  - Stimulus: force-flip one stored bit of entry 0, then pop it.
  - Required: rd_par_err=1 the next cycle and it stays 1. With the macro undefined, rd_par_err stays 0.

Source files
------------

// File: rtl/nios2_oci_dct_capture.sv
// nios2_oci_dct_capture: captures OCI data/control-trace frames into a
// circular buffer, exposes them through a valid/ready read port, and tracks
// test-end signalling (CAPTURE -> DRAIN -> DONE).
// Optional macro NIOS2_OCI_DCT_CAPTURE_PARITY_EN adds a per-entry even-parity
// bit that is rechecked on every pop and reported on the sticky rd_par_err.
module nios2_oci_dct_capture #(
    parameter int DCT_W     = 30,
    parameter int CNT_W     = 4,
    parameter int DEPTH     = 16,
    parameter int WRAP_MODE = 1
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [DCT_W-1:0]               dct_buffer,
    input  logic [CNT_W-1:0]               dct_count,
    input  logic                           test_ending,
    input  logic                           test_has_ended,
    input  logic                           rd_ready,
    output logic                           rd_valid,
    output logic [CNT_W+DCT_W-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]         level,
    output logic                           overflow,
    output logic [15:0]                    drop_count,
    output logic                           capturing,
    output logic                           done,
    output logic                           rd_par_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int DW = CNT_W + DCT_W;
`ifdef NIOS2_OCI_DCT_CAPTURE_PARITY_EN
    localparam int MW = DW + 1;
`else
    localparam int MW = DW;
`endif

    typedef enum logic [1:0] {S_CAPTURE, S_DRAIN, S_DONE} state_t;

    state_t          state, state_next;
    logic [MW-1:0]   mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [LW-1:0]   level_next;
    logic [MW-1:0]   wdata;
    logic            full, push, pop;
    logic            do_write, overwrite, lost, rd_adv;

    assign full     = (level == LW'(DEPTH));
    assign rd_valid = (level != '0);
    assign push     = (dct_count != '0) && (state == S_CAPTURE);
    assign pop      = rd_valid && rd_ready;
    // Memory output is masked so an empty buffer always reads as zero.
    assign rd_data  = rd_valid ? mem[rd_ptr][DW-1:0] : '0;

`ifdef NIOS2_OCI_DCT_CAPTURE_PARITY_EN
    // Parity bit chosen so the whole stored word has even parity.
    assign wdata = {^{dct_count, dct_buffer}, dct_count, dct_buffer};
`else
    assign wdata = {dct_count, dct_buffer};
`endif

    // Decide write/overwrite/drop for this cycle and the resulting occupancy.
    always_comb begin
        do_write  = 1'b0;
        overwrite = 1'b0;
        lost      = 1'b0;
        if (push) begin
            if (!full || pop) begin
                do_write = 1'b1;
            end else if (WRAP_MODE != 0) begin
                do_write  = 1'b1;
                overwrite = 1'b1;
                lost      = 1'b1;
            end else begin
                lost = 1'b1;
            end
        end
        rd_adv     = pop || overwrite;
        level_next = level + LW'(do_write) - LW'(rd_adv);
    end

    // Test-end sequencing; DONE requires the buffer to be empty after this cycle.
    always_comb begin
        state_next = state;
        case (state)
            S_CAPTURE: begin
                if (test_ending)
                    state_next = S_DRAIN;
                else if (test_has_ended && level_next == '0)
                    state_next = S_DONE;
            end
            S_DRAIN: begin
                if (test_has_ended && level_next == '0)
                    state_next = S_DONE;
            end
            default: state_next = S_DONE;
        endcase
    end

    // Storage array; contents are unreachable after reset so it is not cleared.
    always_ff @(posedge clk) begin
        if (do_write)
            mem[wr_ptr] <= wdata;
    end

    // Pointers, occupancy, loss accounting and registered FSM outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_CAPTURE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
            capturing  <= 1'b1;
            done       <= 1'b0;
        end else begin
            state     <= state_next;
            capturing <= (state_next == S_CAPTURE);
            done      <= (state_next == S_DONE);
            level     <= level_next;
            if (do_write)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_adv)
                rd_ptr <= rd_ptr + 1'b1;
            if (lost) begin
                overflow <= 1'b1;
                if (drop_count != 16'hFFFF)
                    drop_count <= drop_count + 16'd1;
            end
        end
    end

`ifdef NIOS2_OCI_DCT_CAPTURE_PARITY_EN
    // Sticky error: any popped entry whose stored word has odd parity.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            rd_par_err <= 1'b0;
        else if (pop && (^mem[rd_ptr]))
            rd_par_err <= 1'b1;
    end
`else
    assign rd_par_err = 1'b0;
`endif

endmodule

// File: tb/tb_nios2_oci_dct_capture.sv
// Bench for nios2_oci_dct_capture: one overwrite-mode and one drop-mode
// instance share stimulus; a queue-based reference model tracks both.
module tb_nios2_oci_dct_capture;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        test_ending, test_has_ended, rd_ready;

    logic        rd_valid_w, rd_valid_d;
    logic [33:0] rd_data_w, rd_data_d;
    logic [4:0]  level_w, level_d;
    logic        overflow_w, overflow_d;
    logic [15:0] drop_count_w, drop_count_d;
    logic        capturing_w, capturing_d, done_w, done_d;
    logic        rd_par_err_w, rd_par_err_d;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: queues hold {count, payload}; both modes see equal sizes.
    logic [33:0] q_w[$];
    logic [33:0] q_d[$];
    int          m_st;      // 0 capture, 1 drain, 2 done
    logic        m_ovf;
    logic [15:0] m_drops;

    always #5 clk = ~clk;

    nios2_oci_dct_capture #(.DCT_W(30), .CNT_W(4), .DEPTH(16), .WRAP_MODE(1)) u_w (
        .clk(clk), .reset_n(reset_n), .dct_buffer(dct_buffer), .dct_count(dct_count),
        .test_ending(test_ending), .test_has_ended(test_has_ended), .rd_ready(rd_ready),
        .rd_valid(rd_valid_w), .rd_data(rd_data_w), .level(level_w), .overflow(overflow_w),
        .drop_count(drop_count_w), .capturing(capturing_w), .done(done_w),
        .rd_par_err(rd_par_err_w));

    nios2_oci_dct_capture #(.DCT_W(30), .CNT_W(4), .DEPTH(16), .WRAP_MODE(0)) u_d (
        .clk(clk), .reset_n(reset_n), .dct_buffer(dct_buffer), .dct_count(dct_count),
        .test_ending(test_ending), .test_has_ended(test_has_ended), .rd_ready(rd_ready),
        .rd_valid(rd_valid_d), .rd_data(rd_data_d), .level(level_d), .overflow(overflow_d),
        .drop_count(drop_count_d), .capturing(capturing_d), .done(done_d),
        .rd_par_err(rd_par_err_d));

    task automatic model_reset();
        q_w.delete();
        q_d.delete();
        m_st    = 0;
        m_ovf   = 1'b0;
        m_drops = '0;
    endtask

    task automatic model_edge();
        bit pop, push;
        pop  = (q_w.size() != 0) && rd_ready;
        push = (dct_count != 0) && (m_st == 0);
        if (pop) begin
            void'(q_w.pop_front());
            void'(q_d.pop_front());
        end
        if (push) begin
            if (q_w.size() < 16) begin
                q_w.push_back({dct_count, dct_buffer});
                q_d.push_back({dct_count, dct_buffer});
            end else begin
                void'(q_w.pop_front());
                q_w.push_back({dct_count, dct_buffer});
                m_ovf = 1'b1;
                if (m_drops != 16'hFFFF) m_drops++;
            end
        end
        if (m_st == 0) begin
            if (test_ending) m_st = 1;
            else if (test_has_ended && q_w.size() == 0) m_st = 2;
        end else if (m_st == 1 && test_has_ended && q_w.size() == 0) begin
            m_st = 2;
        end
    endtask

    task automatic step(input logic [3:0] c, input logic [29:0] pay,
                        input logic r, input logic te, input logic th);
        dct_count = c; dct_buffer = pay; rd_ready = r;
        test_ending = te; test_has_ended = th;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        dct_count = '0; dct_buffer = '0; rd_ready = 1'b0;
        test_ending = 1'b0; test_has_ended = 1'b0;
        #2;
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_vec++;
        if ({level_w, rd_valid_w, rd_data_w, overflow_w, drop_count_w, capturing_w, done_w, rd_par_err_w}
            !== {5'd0, 1'b0, 34'd0, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_w: lvl=%0d vld=%b data=%h ovf=%b drop=%0d cap=%b done=%b par=%b",
                     level_w, rd_valid_w, rd_data_w, overflow_w, drop_count_w, capturing_w, done_w, rd_par_err_w);
        end
        n_vec++;
        if ({level_d, rd_valid_d, overflow_d, drop_count_d, capturing_d, done_d}
            !== {5'd0, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL reset_d: lvl=%0d vld=%b ovf=%b drop=%0d cap=%b done=%b",
                     level_d, rd_valid_d, overflow_d, drop_count_d, capturing_d, done_d);
        end
    endtask

    task automatic test_basic();
        do_reset();
        for (int i = 1; i <= 3; i++) step(4'(i), 30'(i), 1'b0, 1'b0, 1'b0);
        n_vec++;
        if (level_w !== 5'd3 || rd_data_w !== {4'h1, 30'h1}) begin
            n_err++;
            $display("FAIL basic_fill: lvl=%0d data=%h, want 3 / %h", level_w, rd_data_w, {4'h1, 30'h1});
        end
        for (int i = 1; i <= 3; i++) begin
            n_vec++;
            if (rd_valid_w !== 1'b1 || rd_data_w !== {4'(i), 30'(i)}) begin
                n_err++;
                $display("FAIL basic_read%0d: vld=%b data=%h want %h", i, rd_valid_w, rd_data_w, {4'(i), 30'(i)});
            end
            step(4'd0, 30'd0, 1'b1, 1'b0, 1'b0);
        end
        n_vec++;
        if (level_w !== 5'd0 || rd_valid_w !== 1'b0) begin
            n_err++;
            $display("FAIL basic_empty: lvl=%0d vld=%b, want 0/0", level_w, rd_valid_w);
        end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 18; i++) step(4'd1, 30'(i), 1'b0, 1'b0, 1'b0);
        n_vec++;
        if (level_w !== 5'd16 || overflow_w !== 1'b1 || drop_count_w !== 16'd2 || rd_data_w[29:0] !== 30'd2) begin
            n_err++;
            $display("FAIL wrap_full: lvl=%0d ovf=%b drop=%0d pay=%0d, want 16/1/2/2",
                     level_w, overflow_w, drop_count_w, rd_data_w[29:0]);
        end
        n_vec++;
        if (level_d !== 5'd16 || overflow_d !== 1'b1 || drop_count_d !== 16'd2 || rd_data_d[29:0] !== 30'd0) begin
            n_err++;
            $display("FAIL drop_full: lvl=%0d ovf=%b drop=%0d pay=%0d, want 16/1/2/0",
                     level_d, overflow_d, drop_count_d, rd_data_d[29:0]);
        end
        // Full with simultaneous push and pop loses nothing.
        step(4'd1, 30'd100, 1'b1, 1'b0, 1'b0);
        n_vec++;
        if (drop_count_w !== 16'd2 || drop_count_d !== 16'd2 || level_w !== 5'd16 || level_d !== 5'd16) begin
            n_err++;
            $display("FAIL full_pushpop: drop_w=%0d drop_d=%0d lvl_w=%0d lvl_d=%0d, want 2/2/16/16",
                     drop_count_w, drop_count_d, level_w, level_d);
        end
        for (int i = 0; i < 16; i++) begin
            n_vec++;
            if (rd_data_w[29:0] !== ((i == 15) ? 30'd100 : 30'(i + 3)) ||
                rd_data_d[29:0] !== ((i == 15) ? 30'd100 : 30'(i + 1))) begin
                n_err++;
                $display("FAIL full_readout%0d: pay_w=%0d pay_d=%0d, want %0d/%0d", i,
                         rd_data_w[29:0], rd_data_d[29:0], (i == 15) ? 100 : i + 3, (i == 15) ? 100 : i + 1);
            end
            step(4'd0, 30'd0, 1'b1, 1'b0, 1'b0);
        end
    endtask

    task automatic test_drain();
        int reads;
        logic        v;
        logic [33:0] d;
        bit finished;
        do_reset();
        for (int i = 0; i < 5; i++) step(4'd1, 30'(i), 1'b0, 1'b0, 1'b0);
        step(4'd1, 30'd5, 1'b0, 1'b1, 1'b0);
        n_vec++;
        if (level_w !== 5'd6 || capturing_w !== 1'b0 || done_w !== 1'b0) begin
            n_err++;
            $display("FAIL drain_enter: lvl=%0d cap=%b done=%b, want 6/0/0", level_w, capturing_w, done_w);
        end
        reads = 0;
        finished = 0;
        for (int k = 0; k < 20 && !finished; k++) begin
            v = rd_valid_w;
            d = rd_data_w;
            step(4'd2, 30'd99, 1'b1, 1'b0, 1'b1);
            if (v) begin
                n_vec++;
                if (d !== {4'h1, 30'(reads)}) begin
                    n_err++;
                    $display("FAIL drain_data%0d: got %h want %h", reads, d, {4'h1, 30'(reads)});
                end
                reads++;
            end
            n_vec++;
            if (done_w !== (level_w == 5'd0)) begin
                n_err++;
                $display("FAIL drain_done: done=%b with lvl=%0d", done_w, level_w);
            end
            if (level_w == 5'd0) finished = 1;
        end
        n_vec++;
        if (reads != 6 || done_w !== 1'b1 || capturing_w !== 1'b0) begin
            n_err++;
            $display("FAIL drain_total: reads=%0d done=%b cap=%b, want 6/1/0", reads, done_w, capturing_w);
        end
        step(4'd3, 30'd7, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if (level_w !== 5'd0 || rd_valid_w !== 1'b0 || done_w !== 1'b1) begin
            n_err++;
            $display("FAIL done_sticky: lvl=%0d vld=%b done=%b, want 0/0/1", level_w, rd_valid_w, done_w);
        end
    endtask

    task automatic test_async_reset();
        time t0;
        do_reset();
        for (int i = 0; i < 20; i++) step(4'd1, 30'(i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) step(4'd0, 30'd0, 1'b1, 1'b0, 1'b0);
        step(4'd0, 30'd0, 1'b0, 1'b1, 1'b0);
        n_vec++;
        if (level_w !== 5'd7 || capturing_w !== 1'b0 || overflow_w !== 1'b1) begin
            n_err++;
            $display("FAIL areset_pre: lvl=%0d cap=%b ovf=%b, want 7/0/1", level_w, capturing_w, overflow_w);
        end
        #2;
        t0 = $time;
        reset_n = 1'b0;
        #1;
        n_vec++;
        if (level_w !== 5'd0 || rd_valid_w !== 1'b0 || overflow_w !== 1'b0 || capturing_w !== 1'b1 ||
            drop_count_w !== 16'd0 || level_d !== 5'd0 || ($time - t0) >= 5) begin
            n_err++;
            $display("FAIL areset: lvl=%0d vld=%b ovf=%b cap=%b drop=%0d lvl_d=%0d, want 0/0/0/1/0/0",
                     level_w, rd_valid_w, overflow_w, capturing_w, drop_count_w, level_d);
        end
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_random();
        logic [33:0] ew, ed;
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            logic [3:0] c;
            logic r, te, th;
            c  = ($urandom % 2 == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            r  = ($urandom % 4) < 32'((i / 150) % 4);
            te = ($urandom % 90 == 0);
            th = (m_st != 0 || i % 300 > 250) && ($urandom % 6 == 0);
            step(c, 30'($urandom), r, te, th);
            ew = (q_w.size() != 0) ? q_w[0] : 34'd0;
            ed = (q_d.size() != 0) ? q_d[0] : 34'd0;
            n_vec++;
            if ({level_w, rd_valid_w, overflow_w, drop_count_w, capturing_w, done_w, rd_par_err_w, rd_data_w} !==
                {5'(q_w.size()), q_w.size() != 0, m_ovf, m_drops, m_st == 0, m_st == 2, 1'b0, ew}) begin
                n_err++;
                $display("FAIL rand_w cyc%0d: lvl=%0d ovf=%b drop=%0d cap=%b done=%b par=%b data=%h want lvl=%0d ovf=%b drop=%0d st=%0d data=%h",
                         i, level_w, overflow_w, drop_count_w, capturing_w, done_w, rd_par_err_w, rd_data_w,
                         q_w.size(), m_ovf, m_drops, m_st, ew);
            end
            n_vec++;
            if ({level_d, rd_valid_d, overflow_d, drop_count_d, capturing_d, done_d, rd_data_d} !==
                {5'(q_d.size()), q_d.size() != 0, m_ovf, m_drops, m_st == 0, m_st == 2, ed}) begin
                n_err++;
                $display("FAIL rand_d cyc%0d: lvl=%0d ovf=%b drop=%0d data=%h want lvl=%0d ovf=%b drop=%0d data=%h",
                         i, level_d, overflow_d, drop_count_d, rd_data_d, q_d.size(), m_ovf, m_drops, ed);
            end
            if (m_st == 2 && $urandom % 8 == 0) do_reset();
        end
    endtask

    task automatic test_parity();
        do_reset();
        step(4'd3, 30'h15, 1'b0, 1'b0, 1'b0);
`ifdef NIOS2_OCI_DCT_CAPTURE_PARITY_EN
        u_w.mem[0][0] = ~u_w.mem[0][0];
`endif
        step(4'd0, 30'd0, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            n_vec++;
`ifdef NIOS2_OCI_DCT_CAPTURE_PARITY_EN
            if (rd_par_err_w !== 1'b1 || rd_par_err_d !== 1'b0) begin
                n_err++;
                $display("FAIL parity%0d: err_w=%b err_d=%b, want 1/0", k, rd_par_err_w, rd_par_err_d);
            end
`else
            if (rd_par_err_w !== 1'b0 || rd_par_err_d !== 1'b0) begin
                n_err++;
                $display("FAIL parity_off%0d: err_w=%b err_d=%b, want 0/0", k, rd_par_err_w, rd_par_err_d);
            end
`endif
            step(4'd0, 30'd0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        dct_count = '0; dct_buffer = '0; rd_ready = 1'b0;
        test_ending = 1'b0; test_has_ended = 1'b0;
        model_reset();
        test_reset();
        test_basic();
        test_full();
        test_drain();
        test_async_reset();
        test_random();
        test_parity();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
